// File: rtl/pinmux_matrix_if.sv
// Peripheral bus (OBI subset) between the bus master and the pinmux register file.
interface pinmux_matrix_if;
  logic        req_i;
  logic        we_i;
  logic [3:0]  be_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic        gnt_o;
  logic        rvalid_o;
  logic [31:0] data_o;

  modport master (
    output req_i, we_i, be_i, addr_i, data_i,
    input  gnt_o, rvalid_o, data_o
  );

  modport slave (
    input  req_i, we_i, be_i, addr_i, data_i,
    output gnt_o, rvalid_o, data_o
  );
endinterface

// File: rtl/pinmux_matrix.sv
// Pad/function matrix with synchronised, debounced inputs, guarded select switchover and config lock.
// Pad outputs and bus responses are registered (1 cycle); gnt follows req, so the bus never stalls.
module pinmux_matrix #(
  parameter int unsigned     IO_NUM       = 16,
  parameter int unsigned     FUNC_NUM     = 4,
  parameter int unsigned     SYNC_STAGES  = 2,
  parameter int unsigned     DB_W         = 8,
  parameter logic [DB_W-1:0] DB_DEFAULT   = DB_W'(4),
  parameter int unsigned     GUARD_CYCLES = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [IO_NUM*FUNC_NUM-1:0] func_oe_i,
  input  logic [IO_NUM*FUNC_NUM-1:0] func_val_i,
  output logic [IO_NUM*FUNC_NUM-1:0] func_val_o,
  input  logic [IO_NUM-1:0]          io_val_i,
  output logic [IO_NUM-1:0]          io_val_o,
  output logic [IO_NUM-1:0]          io_oe_o,
  pinmux_matrix_if.slave             bus
);

  localparam int unsigned NW = (IO_NUM + 7) / 8;
  localparam int unsigned NB = IO_NUM * FUNC_NUM;
  localparam int unsigned IW = (NB < 2) ? 1 : $clog2(NB);
  localparam int unsigned GW = (GUARD_CYCLES < 2) ? 1 : $clog2(GUARD_CYCLES + 1);

  typedef enum logic {RUN, GUARD} guard_state_e;

  logic [3:0]      sel_q   [IO_NUM];
  logic [3:0]      sel_d   [IO_NUM];
  guard_state_e    gst_q   [IO_NUM];
  guard_state_e    gst_d   [IO_NUM];
  logic [GW-1:0]   gcnt_q  [IO_NUM];
  logic [GW-1:0]   gcnt_d  [IO_NUM];
  logic [DB_W-1:0] dbcnt_q [IO_NUM];
  logic [DB_W-1:0] dbcnt_d [IO_NUM];
  logic [IO_NUM-1:0] sync_q [SYNC_STAGES];
  logic [IO_NUM-1:0] sync_d [SYNC_STAGES];
  logic [IW-1:0]   oidx    [IO_NUM];
  logic [IW-1:0]   fidx    [IO_NUM];

  logic [IO_NUM-1:0] db_en_q, db_en_d;
  logic [DB_W-1:0]   db_thr_q, db_thr_d;
  logic              lock_q, lock_d;
  logic [IO_NUM-1:0] filt_q, filt_d;
  logic [IO_NUM-1:0] io_oe_q, io_oe_d;
  logic [IO_NUM-1:0] io_val_q, io_val_d;
  logic              rvalid_q, rvalid_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [DB_W-1:0]   thr_eff;

  logic [11:0] addr;
  logic        wr_acc, rd_acc, sel_hit;
  logic        unused_bits;

  assign addr        = bus.addr_i[11:0];
  assign wr_acc      = bus.req_i & bus.we_i;
  assign rd_acc      = bus.req_i & ~bus.we_i;
  assign sel_hit     = (addr[11:8] == 4'h0) && (int'(addr[7:2]) < int'(NW));
  assign unused_bits = ^{bus.addr_i[31:12], bus.addr_i[1:0]};

  assign bus.gnt_o    = bus.req_i;
  assign bus.rvalid_o = rvalid_q;
  assign bus.data_o   = rdata_q;
  assign io_oe_o      = io_oe_q;
  assign io_val_o     = io_val_q;

  // Configuration registers; the lock only blocks SEL/DB_EN/DB_THR, never itself.
  always_comb begin
    sel_d    = sel_q;
    db_en_d  = db_en_q;
    db_thr_d = db_thr_q;
    lock_d   = lock_q;
    if (wr_acc && !lock_q) begin
      if (sel_hit) begin
        for (int p = 0; p < int'(IO_NUM); p++) begin
          if ((p / 8 == int'(addr[7:2])) && bus.be_i[(p % 8) / 2] &&
              (32'(bus.data_i[4*(p%8) +: 4]) < FUNC_NUM)) begin
            sel_d[p] = bus.data_i[4*(p%8) +: 4];
          end
        end
      end else if (addr[11:2] == 10'h040) begin
        for (int p = 0; p < int'(IO_NUM); p++) begin
          if (bus.be_i[p / 8]) db_en_d[p] = bus.data_i[p];
        end
      end else if (addr[11:2] == 10'h041) begin
        for (int j = 0; j < int'(DB_W); j++) begin
          if (bus.be_i[j / 8]) db_thr_d[j] = bus.data_i[j];
        end
      end
    end
    if (wr_acc && (addr[11:2] == 10'h042) && bus.be_i[0] && bus.data_i[0]) begin
      lock_d = 1'b1;
    end
  end

  always_comb begin
    rvalid_d = bus.req_i;
    rdata_d  = '0;
    if (rd_acc) begin
      if (sel_hit) begin
        for (int p = 0; p < int'(IO_NUM); p++) begin
          if (p / 8 == int'(addr[7:2])) rdata_d[4*(p%8) +: 4] = sel_q[p];
        end
      end else begin
        case (addr[11:2])
          10'h040: rdata_d = 32'(db_en_q);
          10'h041: rdata_d = 32'(db_thr_q);
          10'h042: rdata_d = 32'(lock_q);
          10'h043: rdata_d = 32'(filt_q);
          default: rdata_d = '0;
        endcase
      end
    end
  end

  // Guard FSM and output mux; outputs are blanked from the very edge a select change is accepted.
  always_comb begin
    io_oe_d  = '0;
    io_val_d = '0;
    for (int p = 0; p < int'(IO_NUM); p++) begin
      gst_d[p]  = gst_q[p];
      gcnt_d[p] = gcnt_q[p];
      oidx[p]   = IW'(p * int'(FUNC_NUM)) + IW'(sel_d[p]);
      if ((GUARD_CYCLES > 0) && (sel_d[p] != sel_q[p])) begin
        gst_d[p]  = GUARD;
        gcnt_d[p] = GW'(GUARD_CYCLES);
      end else if (gst_q[p] == GUARD) begin
        gcnt_d[p] = gcnt_q[p] - GW'(1);
        if (gcnt_q[p] == GW'(1)) gst_d[p] = RUN;
      end
      if (gst_d[p] == RUN) begin
        io_oe_d[p]  = func_oe_i[oidx[p]];
        io_val_d[p] = func_val_i[oidx[p]];
      end
    end
  end

  always_comb begin
    func_val_o = '0;
    for (int p = 0; p < int'(IO_NUM); p++) begin
      fidx[p] = IW'(p * int'(FUNC_NUM)) + IW'(sel_q[p]);
      if (gst_q[p] == RUN) func_val_o[fidx[p]] = filt_q[p];
    end
  end

  // A zero threshold behaves like 1 so an enabled filter still tracks the input.
  assign thr_eff = (db_thr_q == '0) ? DB_W'(1) : db_thr_q;

  always_comb begin
    sync_d[0] = io_val_i;
    for (int s = 1; s < int'(SYNC_STAGES); s++) sync_d[s] = sync_q[s-1];
    filt_d = filt_q;
    for (int p = 0; p < int'(IO_NUM); p++) begin
      dbcnt_d[p] = '0;
      if (!db_en_q[p]) begin
        filt_d[p] = sync_q[SYNC_STAGES-1][p];
      end else if (sync_q[SYNC_STAGES-1][p] != filt_q[p]) begin
        if ((DB_W+1)'(dbcnt_q[p]) + (DB_W+1)'(1) >= (DB_W+1)'(thr_eff)) begin
          filt_d[p] = sync_q[SYNC_STAGES-1][p];
        end else begin
          dbcnt_d[p] = dbcnt_q[p] + DB_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int p = 0; p < int'(IO_NUM); p++) begin
        sel_q[p]   <= '0;
        gst_q[p]   <= RUN;
        gcnt_q[p]  <= '0;
        dbcnt_q[p] <= '0;
      end
      for (int s = 0; s < int'(SYNC_STAGES); s++) sync_q[s] <= '0;
      db_en_q  <= '0;
      db_thr_q <= DB_DEFAULT;
      lock_q   <= 1'b0;
      filt_q   <= '0;
      io_oe_q  <= '0;
      io_val_q <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      sel_q    <= sel_d;
      gst_q    <= gst_d;
      gcnt_q   <= gcnt_d;
      dbcnt_q  <= dbcnt_d;
      sync_q   <= sync_d;
      db_en_q  <= db_en_d;
      db_thr_q <= db_thr_d;
      lock_q   <= lock_d;
      filt_q   <= filt_d;
      io_oe_q  <= io_oe_d;
      io_val_q <= io_val_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule

// File: doc/pinmux_matrix.md
Name: pinmux_matrix

Overview:
- Parametrised pin multiplexer with a register-configurable function matrix. Each of IO_NUM pads selects one of FUNC_NUM peripheral functions.
- Adds features beyond a fixed pinmux: 2-FF input synchronisation, per-pad debounce filter, glitch-free function switchover with a guard interval, and a sticky configuration lock.
- Sits between the peripheral cluster and the pad ring and is configured over the OBI peripheral bus.

Parameters:
- IO_NUM, 16, number of pads (1..32).
- FUNC_NUM, 4, functions per pad (2..16). Function 0 is the GPIO.
- SYNC_STAGES, 2, input synchroniser depth (>=2).
- DB_W, 8, debounce threshold/counter width.
- DB_DEFAULT, 8'd4, reset value of the debounce threshold.
- GUARD_CYCLES, 4, output-disable cycles on a select change. 0 disables the guard.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- func_oe_i  in  IO_NUM*FUNC_NUM  output enable; bit index p*FUNC_NUM+f is pad p, function f.
- func_val_i  in  IO_NUM*FUNC_NUM  output value, same indexing.
- func_val_o  out  IO_NUM*FUNC_NUM  pad input routed to the selected function, same indexing.
- io_val_i  in  IO_NUM  raw asynchronous pad input.
- io_val_o  out  IO_NUM  pad output value.
- io_oe_o  out  IO_NUM  pad output enable.
- req_i  in  1  OBI request.
- we_i  in  1  write enable.
- be_i  in  4  byte enables.
- addr_i  in  32  address; only [11:0] is decoded.
- data_i  in  32  write data.
- gnt_o  out  1  grant.
- rvalid_o  out  1  response valid.
- data_o  out  32  read data.

Behaviour:
- Reset (synchronous, rst_i=1 at clk_i edge) clears the following. Reset mid-guard or mid-debounce aborts it cleanly.
  - Outputs: io_oe_o=0, io_val_o=0, func_val_o=0, rvalid_o=0, data_o=0.
  - Registers: all SEL=0, LOCK=0, DB_EN=0, DB_THR=DB_DEFAULT.
  - Internal state: guard counters=0, debounce counters=0, sync chains=0, filtered values=0.
- Bus handshake:
  - gnt_o=req_i (combinational).
  - rvalid_o is asserted one cycle after every accepted request.
  - data_o is registered in the same cycle; it is 0 for writes and for unmapped reads.
  - Writes take effect at the accept edge, so a read on the next cycle returns the new value.
- Register map:
  - 0x000+4k: SEL word k. Pad 8k+i uses bits [4i+3:4i].
  - 0x100: DB_EN[IO_NUM-1:0].
  - 0x104: DB_THR[DB_W-1:0].
  - 0x108: LOCK[0]. Write-1 sets it; only reset clears it.
  - 0x10C: STATUS, filtered pad inputs (read-only).
  - Bits above the implemented width read 0.
- Write rules:
  - be_i gates bytes; one byte covers two SEL nibbles.
  - A SEL nibble written with a value >=FUNC_NUM is ignored; that pad keeps its old value.
  - While LOCK=1, writes to SEL, DB_EN and DB_THR are ignored. Reads still work.
- Output path (registered, 1-cycle latency):
  - io_oe_o[p] <= func_oe_i[p*F+sel[p]].
  - io_val_o[p] <= func_val_i[p*F+sel[p]].
- Guard FSM per pad:
  - States: RUN and GUARD.
  - RUN→GUARD: an accepted write changes sel[p] and GUARD_CYCLES>0. The counter loads GUARD_CYCLES.
  - In GUARD the counter decrements each cycle. io_oe_o[p]=0, io_val_o[p]=0, and all func_val_o for pad p are 0.
  - GUARD→RUN: when the counter reaches 0. The output resumes on the next cycle.
  - Rewriting the same value: no guard.
  - A new differing write during GUARD reloads the counter.
- Input path:
  - io_val_i passes through SYNC_STAGES flops to give sync[p], then a filtered register filt[p].
  - DB_EN[p]=0: filt<=sync each cycle. Latency is SYNC_STAGES+1 cycles.
  - DB_EN[p]=1: the counter increments each cycle while sync!=filt. It clears when sync==filt.
  - filt toggles, and the counter clears, in the cycle the counter would reach max(DB_THR,1).
  - Pulses shorter than DB_THR cycles never reach filt.
  - Counter width is DB_W. Saturation is impossible because it clears at threshold.
- func_val_o:
  - func_val_o[p*F+sel[p]] = filt[p] (registered path), except during GUARD where it is 0.
  - All non-selected function bits are 0.

Test Plan:
- Reset, then read 0x000 and 0x10C → rvalid_o=1 one cycle after req_i, data_o=0. io_oe_o=0.
- Write SEL pad3=2 (0x000, data 0x2000, be=4'b0010); drive func_oe_i[3*4+2]=1, func_val_i=1 → io_oe_o[3]=0 for 4 cycles, then io_oe_o[3]=1, io_val_o[3]=1. func_val_o[3*4+0]=0.
- Write SEL pad0=2, then pad0=1 two cycles later → guard counter reloads; io_oe_o[0] stays 0 for 4 cycles after the second write.
- DB_EN[5]=1, DB_THR=4; 3-cycle high pulse on io_val_i[5] → STATUS[5] stays 0. A 10-cycle pulse → STATUS[5]=1 exactly SYNC_STAGES+4 cycles after the rising edge.
- Write LOCK=1, then write SEL word0=0xFFFF_FFFF → readback unchanged. Assert rst_i → LOCK reads 0.
- Write SEL nibble value 7 with FUNC_NUM=4 → nibble ignored; byte-masked neighbouring nibbles are updated correctly.
